// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared constants for the BCD to Excess-3 converter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bcd_pkg;
  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] EX3_INVALID = 4'b0000;
endpackage

`default_nettype wire

// File: rtl/bcd_ex3_comb.sv
// ============================================================================
// bcd_ex3_comb : combinational BCD digit to Excess-3 decode with invalid flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_ex3_comb
  import bcd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [3:0] o_ex3,
  output logic       o_invalid
);

  logic w_invalid;

  assign w_invalid = (i_bcd > BCD_MAX);
  assign o_invalid = w_invalid;
  // Non-BCD codes are squashed to zero rather than wrapping through the adder
  assign o_ex3     = w_invalid ? EX3_INVALID : (i_bcd + EX3_OFFSET);

endmodule

`default_nettype wire

// File: rtl/bcd_to_excess3.sv
// ============================================================================
// bcd_to_excess3 : registered single-digit BCD to Excess-3 converter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_to_excess3
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic s3,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic out_valid,
  output logic err,
  output logic err_sticky
);

  logic [3:0] w_bcd;
  logic [3:0] w_ex3;
  logic       w_invalid;

  logic [3:0] r_ex3;
  logic       r_out_valid;
  logic       r_err;
  logic       r_err_sticky;

  assign w_bcd = {a, b, c, d};

  bcd_ex3_comb u_core (
    .i_bcd     (w_bcd),
    .o_ex3     (w_ex3),
    .o_invalid (w_invalid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex3        <= EX3_INVALID;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      // Result and err hold across idle cycles; only accepted digits update them
      if (in_valid) begin
        r_ex3 <= w_ex3;
        r_err <= w_invalid;
        if (w_invalid) begin
          r_err_sticky <= 1'b1;
        end
      end
    end
  end

  assign {s3, s2, s1, s0} = r_ex3;
  assign out_valid        = r_out_valid;
  assign err              = r_err;
  assign err_sticky       = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_excess3.sv
// ============================================================================
// tb_bcd_to_excess3 : directed + randomized check against a digit-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_excess3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic s3, s2, s1, s0, out_valid, err, err_sticky;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int m_ex3 = 0;
  bit m_ov = 0, m_err = 0, m_sticky = 0;

  bcd_to_excess3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .s3         (s3),
    .s2         (s2),
    .s1         (s1),
    .s0         (s0),
    .out_valid  (out_valid),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare every output
  task automatic step(input bit rstn, input bit iv, input int digit);
    logic [3:0] dig;
    dig = digit[3:0];
    rst_n    = rstn;
    in_valid = iv;
    {a, b, c, d} = dig;
    @(posedge clk);
    #1;
    if (!rstn) begin
      m_ex3 = 0; m_ov = 0; m_err = 0; m_sticky = 0;
    end else begin
      m_ov = iv;
      if (iv) begin
        m_err = (digit >= 10);
        m_ex3 = m_err ? 0 : digit + 3;
        if (m_err) m_sticky = 1;
      end
    end
    check("ex3",        {s3, s2, s1, s0}, 4'(m_ex3));
    check("out_valid",  {3'b0, out_valid},  {3'b0, m_ov});
    check("err",        {3'b0, err},        {3'b0, m_err});
    check("err_sticky", {3'b0, err_sticky}, {3'b0, m_sticky});
  endtask

  initial begin
    // Reset for two cycles
    step(0, 0, 0);
    step(0, 0, 0);
    check("reset_ex3_const", {s3, s2, s1, s0}, 4'b0000);

    // Sweep valid digits back to back
    for (int i = 0; i < 10; i++) step(1, 1, i);
    check("sweep_last", {s3, s2, s1, s0}, 4'b1100);

    // Invalid codes then recovery
    step(1, 1, 10);
    step(1, 1, 15);
    check("inv_sticky", {3'b0, err_sticky}, 4'd1);
    step(1, 1, 5);
    check("recover_ex3", {s3, s2, s1, s0}, 4'b1000);

    // Hold while in_valid low with toggling inputs
    step(1, 1, 7);
    for (int i = 0; i < 3; i++) step(1, 0, (i * 5 + 3) % 16);
    check("hold_ex3", {s3, s2, s1, s0}, 4'b1010);

    // Reset collides with a valid input
    step(0, 1, 9);
    check("rst_prio_valid", {3'b0, out_valid}, 4'd0);

    // Exhaustive 16 codes
    for (int i = 0; i < 16; i++) step(1, 1, i);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 24) != 0), $urandom_range(0, 1), $urandom_range(0, 15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
